// File: rtl/coffee_dispenser_if.sv
// Controller-side signals of the coffee dispenser: brew request/completion,
// refill button, actuator drives and status.
interface coffee_dispenser_if;
  logic       coffee_make;
  logic       cup_refill;
  logic       coffee_out;
  logic       cup_drop;
  logic       heater_on;
  logic       valve_open;
  logic       busy;
  logic       fault;
  logic [7:0] cups_left;

  modport master (
    output coffee_make, cup_refill,
    input  coffee_out, cup_drop, heater_on, valve_open, busy, fault, cups_left
  );

  modport slave (
    input  coffee_make, cup_refill,
    output coffee_out, cup_drop, heater_on, valve_open, busy, fault, cups_left
  );
endinterface

// File: rtl/coffee_dispenser.sv
// Coffee dispenser sequencer: cup drop, brew and pour phases timed in
// prescaled ticks, with cup stock tracking and an empty-stock fault state.
module coffee_dispenser #(
  parameter int TICK_DIV     = 100000,
  parameter int CUP_TICKS    = 500,
  parameter int BREW_TICKS   = 3000,
  parameter int POUR_TICKS   = 2000,
  parameter int CUP_CAPACITY = 50
) (
  input  logic              clk,
  input  logic              reset,
  coffee_dispenser_if.slave dsp
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_A = (CUP_TICKS > BREW_TICKS) ? CUP_TICKS : BREW_TICKS;
  localparam int MAXT  = (MAX_A > POUR_TICKS) ? MAX_A : POUR_TICKS;
  localparam int TW    = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] CUP_LAST   = TW'(CUP_TICKS - 1);
  localparam logic [TW-1:0] BREW_LAST  = TW'(BREW_TICKS - 1);
  localparam logic [TW-1:0] POUR_LAST  = TW'(POUR_TICKS - 1);
  localparam logic [7:0]    CAP        = 8'(CUP_CAPACITY);

  typedef enum logic [2:0] {
    IDLE, CUP, BREW, POUR, DONE, WAIT_REL, EMPTY
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] phase_last;
  logic          refill_q;
  logic [7:0]    cups, cups_nxt;
  logic          refill_rise;
  logic          presc_wrap;
  logic          phase_end;
  logic          take_cup;

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  assign refill_rise = dsp.cup_refill & ~refill_q;
  assign presc_wrap  = (presc == PRESC_LAST);

  always_comb begin
    phase_last = '0;
    case (state)
      CUP:     phase_last = CUP_LAST;
      BREW:    phase_last = BREW_LAST;
      POUR:    phase_last = POUR_LAST;
      default: phase_last = '0;
    endcase
  end

  // A phase ends on the last prescaler cycle of its last tick.
  assign phase_end = presc_wrap && (tick_cnt == phase_last);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dsp.coffee_make)
          state_nxt = ((cups != 8'd0) || refill_rise) ? CUP : EMPTY;
      end
      CUP:      if (phase_end) state_nxt = BREW;
      BREW:     if (phase_end) state_nxt = POUR;
      POUR:     if (phase_end) state_nxt = DONE;
      DONE:     state_nxt = WAIT_REL;
      WAIT_REL: if (!dsp.coffee_make) state_nxt = IDLE;
      EMPTY: begin
        if (refill_rise)
          state_nxt = dsp.coffee_make ? CUP : IDLE;
        else if (!dsp.coffee_make)
          state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // A cup is consumed on the edge that enters CUP; a simultaneous refill
  // still leaves that cup taken.
  assign take_cup = (state_nxt == CUP) && (state != CUP);

  always_comb begin
    cups_nxt = cups;
    if (refill_rise)
      cups_nxt = take_cup ? sat_dec(CAP) : CAP;
    else if (take_cup)
      cups_nxt = sat_dec(cups);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      tick_cnt <= '0;
      refill_q <= 1'b0;
      cups     <= CAP;
    end else begin
      state    <= state_nxt;
      refill_q <= dsp.cup_refill;
      cups     <= cups_nxt;
      if (state_nxt != state) begin
        presc    <= '0;
        tick_cnt <= '0;
      end else if (presc_wrap) begin
        presc    <= '0;
        tick_cnt <= tick_cnt + 1'b1;
      end else begin
        presc    <= presc + 1'b1;
      end
    end
  end

  assign dsp.cup_drop   = (state == CUP);
  assign dsp.heater_on  = (state == BREW);
  assign dsp.valve_open = (state == POUR);
  assign dsp.coffee_out = (state == DONE);
  assign dsp.fault      = (state == EMPTY);
  assign dsp.busy       = (state != IDLE);
  assign dsp.cups_left  = cups;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Scoreboard bench for coffee_dispenser with short phase timing: stimulus
// queues expected output snapshots and completions, a negedge monitor checks.
module tb_coffee_dispenser;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   tag_n;

  coffee_dispenser_if bus ();

  coffee_dispenser #(
    .TICK_DIV    (2),
    .CUP_TICKS   (2),
    .BREW_TICKS  (3),
    .POUR_TICKS  (2),
    .CUP_CAPACITY(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dsp  (bus)
  );

  // outs = {coffee_out, cup_drop, heater_on, valve_open, busy, fault}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_CUP   = 6'b010010;
  localparam logic [5:0] O_BREW  = 6'b001010;
  localparam logic [5:0] O_POUR  = 6'b000110;
  localparam logic [5:0] O_DONE  = 6'b100010;
  localparam logic [5:0] O_WAIT  = 6'b000010;
  localparam logic [5:0] O_EMPTY = 6'b000011;

  typedef struct {
    int         cyc;
    int         tag;
    logic [5:0] outs;
    logic [7:0] cups;
  } snap_t;

  typedef struct {
    int         cyc;
    logic [7:0] cups;
  } done_t;

  snap_t snapq[$];
  done_t doneq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare snapshots due this cycle and every coffee_out pulse.
  always @(negedge clk) begin
    logic [5:0] outs;
    snap_t      s;
    done_t      d;
    outs = {bus.coffee_out, bus.cup_drop, bus.heater_on, bus.valve_open, bus.busy, bus.fault};
    while (snapq.size() > 0 && snapq[0].cyc <= cyc) begin
      s = snapq.pop_front();
      n_checks++;
      if (s.cyc != cyc || outs !== s.outs || bus.cups_left !== s.cups) begin
        n_fail++;
        $display("FAIL snap%0d cyc=%0d: outs=%b cups_left=%0d, required cyc=%0d outs=%b cups_left=%0d",
                 s.tag, cyc, outs, bus.cups_left, s.cyc, s.outs, s.cups);
      end
    end
    while (doneq.size() > 0 && doneq[0].cyc < cyc) begin
      d = doneq.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL coffee_out_missing: no pulse seen, required at cyc=%0d", d.cyc);
    end
    if (bus.coffee_out === 1'b1) begin
      n_checks++;
      if (doneq.size() == 0) begin
        n_fail++;
        $display("FAIL coffee_out_unexpected: pulse at cyc=%0d, required none", cyc);
      end else begin
        d = doneq.pop_front();
        if (d.cyc != cyc || bus.cups_left !== d.cups) begin
          n_fail++;
          $display("FAIL coffee_out: cyc=%0d cups_left=%0d, required cyc=%0d cups_left=%0d",
                   cyc, bus.cups_left, d.cyc, d.cups);
        end
      end
    end
  end

  task automatic exp_at(input int off, input logic [5:0] o, input logic [7:0] c);
    snap_t s;
    s.cyc  = cyc + off;
    s.tag  = tag_n;
    s.outs = o;
    s.cups = c;
    tag_n++;
    snapq.push_back(s);
  endtask

  // Expected cycles 1..15 of a brew started on the coming edge.
  task automatic push_brew_exp(input logic [7:0] c);
    done_t d;
    for (int k = 1; k <= 4; k++)   exp_at(k, O_CUP, c);
    for (int k = 5; k <= 10; k++)  exp_at(k, O_BREW, c);
    for (int k = 11; k <= 14; k++) exp_at(k, O_POUR, c);
    exp_at(15, O_DONE, c);
    d.cyc  = cyc + 15;
    d.cups = c;
    doneq.push_back(d);
  endtask

  // Full brew; coffee_make drops at cycle drop_at (<=15), ends back in IDLE.
  task automatic run_brew(input logic [7:0] c, input bit refill, input int drop_at);
    bus.coffee_make = 1'b1;
    bus.cup_refill  = refill;
    push_brew_exp(c);
    exp_at(16, O_WAIT, c);
    exp_at(17, O_IDLE, c);
    @(negedge clk);
    bus.cup_refill = 1'b0;
    repeat (drop_at - 1) @(negedge clk);
    bus.coffee_make = 1'b0;
    repeat (17 - drop_at) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    tag_n           = 0;
    reset           = 1'b1;
    bus.coffee_make = 1'b0;
    bus.cup_refill  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    exp_at(1, O_IDLE, 8'd3);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic brew with coffee_make held 10 cycles past completion
    bus.coffee_make = 1'b1;
    push_brew_exp(8'd2);
    for (int k = 16; k <= 25; k++) exp_at(k, O_WAIT, 8'd2);
    repeat (25) @(negedge clk);
    bus.coffee_make = 1'b0;
    exp_at(1, O_IDLE, 8'd2);
    @(negedge clk);

    run_brew(8'd1, 1'b0, 15);

    // Refill button held high in IDLE
    bus.cup_refill = 1'b1;
    for (int k = 1; k <= 21; k++) exp_at(k, O_IDLE, 8'd3);
    repeat (20) @(negedge clk);
    bus.cup_refill = 1'b0;
    repeat (2) @(negedge clk);

    // Exhaust stock
    run_brew(8'd2, 1'b0, 15);
    run_brew(8'd1, 1'b0, 15);
    run_brew(8'd0, 1'b0, 15);

    // Request with no cups, then withdraw: no wrap below zero
    bus.coffee_make = 1'b1;
    for (int k = 1; k <= 3; k++) exp_at(k, O_EMPTY, 8'd0);
    repeat (3) @(negedge clk);
    bus.coffee_make = 1'b0;
    exp_at(1, O_IDLE, 8'd0);
    exp_at(2, O_IDLE, 8'd0);
    repeat (2) @(negedge clk);

    // Request again, then refill while faulted
    bus.coffee_make = 1'b1;
    exp_at(1, O_EMPTY, 8'd0);
    exp_at(2, O_EMPTY, 8'd0);
    repeat (2) @(negedge clk);
    run_brew(8'd2, 1'b1, 15);

    // coffee_make dropped during POUR
    run_brew(8'd1, 1'b0, 12);

    // Refill coincident with IDLE->CUP
    run_brew(8'd2, 1'b1, 15);

    // Reset asserted mid-BREW with coffee_make still high
    bus.coffee_make = 1'b1;
    for (int k = 1; k <= 4; k++) exp_at(k, O_CUP, 8'd1);
    for (int k = 5; k <= 7; k++) exp_at(k, O_BREW, 8'd1);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_at(0, O_IDLE, 8'd3);
    @(negedge clk);
    reset = 1'b0;
    run_brew(8'd2, 1'b0, 15);

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (snapq.size() != 0) begin
      n_fail++;
      $display("FAIL snap_queue_drained: %0d left, required 0", snapq.size());
    end
    n_checks++;
    if (doneq.size() != 0) begin
      n_fail++;
      $display("FAIL done_queue_drained: %0d left, required 0", doneq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
